// File: rtl/multi_channel_counter.sv
// multi_channel_counter: NUM_CH independent up/down counters. Each channel
// has a programmable limit, wrap or saturate behaviour, synchronous clear and
// load, and a registered terminal-count pulse. All state updates on the falling
// clock edge so it lines up with the core's existing counters.
//
// Each channel's priority is clr > load > en; an idle channel holds its count.
// Outputs are all registered, so no input reaches out, tc or any_tc within the
// same cycle.
module multi_channel_counter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SATURATE   = 0,
  parameter int RESET_ONES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            en,
  input  logic [NUM_CH-1:0]            dir,
  input  logic [NUM_CH-1:0]            clr,
  input  logic [NUM_CH-1:0]            load,
  input  logic [NUM_CH*DATA_WIDTH-1:0] load_val,
  input  logic [NUM_CH*DATA_WIDTH-1:0] limit,
  output logic [NUM_CH*DATA_WIDTH-1:0] out,
  output logic [NUM_CH-1:0]            tc,
  output logic                         any_tc
);

  localparam logic [DATA_WIDTH-1:0] CNT_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] CH_RST  = (RESET_ONES != 0) ? {DATA_WIDTH{1'b1}}
                                                                : {DATA_WIDTH{1'b0}};
  localparam logic [NUM_CH*DATA_WIDTH-1:0] OUT_RST = {NUM_CH{CH_RST}};

  // One channel's next state. The result packs {terminal, next_count}.
  function automatic logic [DATA_WIDTH:0] step_fn(
    input logic                  c_clr,
    input logic                  c_load,
    input logic                  c_en,
    input logic                  c_up,
    input logic [DATA_WIDTH-1:0] cur,
    input logic [DATA_WIDTH-1:0] lv,
    input logic [DATA_WIDTH-1:0] lim
  );
    logic [DATA_WIDTH:0] r;
    r                   = '0;
    r[DATA_WIDTH-1:0]   = cur;
    if (c_clr) begin
      r[DATA_WIDTH-1:0] = '0;
    end else if (c_load) begin
      // The load value is taken as given and is not clipped to the limit.
      r[DATA_WIDTH-1:0] = lv;
    end else if (c_en && c_up) begin
      if (cur == lim) begin
        r[DATA_WIDTH]     = 1'b1;
        r[DATA_WIDTH-1:0] = (SATURATE != 0) ? cur : '0;
      end else begin
        // An out-of-range count walks past limit and wraps at 2^DATA_WIDTH.
        r[DATA_WIDTH-1:0] = cur + CNT_ONE;
      end
    end else if (c_en) begin
      if (cur == '0) begin
        r[DATA_WIDTH]     = 1'b1;
        r[DATA_WIDTH-1:0] = (SATURATE != 0) ? cur : lim;
      end else begin
        r[DATA_WIDTH-1:0] = cur - CNT_ONE;
      end
    end
    return r;
  endfunction

  logic [NUM_CH*DATA_WIDTH-1:0] out_d;
  logic [NUM_CH-1:0]            tc_d;

  // Next-state computation for each channel; channels never share a term.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DATA_WIDTH:0] nxt;
    assign nxt = step_fn(clr[i], load[i], en[i], dir[i],
                         out[i*DATA_WIDTH +: DATA_WIDTH],
                         load_val[i*DATA_WIDTH +: DATA_WIDTH],
                         limit[i*DATA_WIDTH +: DATA_WIDTH]);
    assign out_d[i*DATA_WIDTH +: DATA_WIDTH] = nxt[DATA_WIDTH-1:0];
    assign tc_d[i]                           = nxt[DATA_WIDTH];
  end

  // Register counts, tc pulses and their OR on the falling edge; async reset.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      out    <= OUT_RST;
      tc     <= '0;
      any_tc <= 1'b0;
    end else begin
      out    <= out_d;
      tc     <= tc_d;
      any_tc <= |tc_d;
    end
  end

endmodule

// File: tb/tb_multi_channel_counter.sv
// Bench for multi_channel_counter: a wrap instance and a saturate instance
// share one set of inputs, and each is compared against an arithmetic model
// after every falling edge.
module tb_multi_channel_counter;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int MAXV = 1 << W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]   en, dir, clr, load;
  logic [NCH*W-1:0] load_val, limit;
  logic [NCH*W-1:0] out_w, out_s;
  logic [NCH-1:0]   tc_w, tc_s;
  logic             any_w, any_s;

  multi_channel_counter #(.NUM_CH(NCH), .DATA_WIDTH(W), .SATURATE(0), .RESET_ONES(1)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .limit(limit), .out(out_w), .tc(tc_w), .any_tc(any_w)
  );

  multi_channel_counter #(.NUM_CH(NCH), .DATA_WIDTH(W), .SATURATE(1), .RESET_ONES(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .limit(limit), .out(out_s), .tc(tc_s), .any_tc(any_s)
  );

  // ---------------- reference model ----------------
  // Index 0 models the wrap instance, index 1 the saturate instance.
  int m_cnt [2][NCH];
  bit m_tc  [2][NCH];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int field(input logic [NCH*W-1:0] v, input int i);
    logic [NCH*W-1:0] t;
    t = v >> (i * W);
    return int'(t[W-1:0]);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NCH; i++) begin
        m_cnt[s][i] = MAXV - 1;
        m_tc[s][i]  = 1'b0;
      end
  endtask

  task automatic model_step();
    int lim;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NCH; i++) begin
        lim = field(limit, i);
        m_tc[s][i] = 1'b0;
        if (clr[i]) m_cnt[s][i] = 0;
        else if (load[i]) m_cnt[s][i] = field(load_val, i);
        else if (en[i] && dir[i]) begin
          if (m_cnt[s][i] == lim) begin
            m_tc[s][i] = 1'b1;
            if (s == 0) m_cnt[s][i] = 0;
          end else m_cnt[s][i] = (m_cnt[s][i] + 1) % MAXV;
        end else if (en[i]) begin
          if (m_cnt[s][i] == 0) begin
            m_tc[s][i] = 1'b1;
            if (s == 0) m_cnt[s][i] = lim;
          end else m_cnt[s][i] = m_cnt[s][i] - 1;
        end
      end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string phase);
    logic [NCH*W-1:0] o;
    logic [NCH-1:0]   t;
    logic             a;
    logic [NCH-1:0]   et;
    for (int s = 0; s < 2; s++) begin
      o = (s == 0) ? out_w : out_s;
      t = (s == 0) ? tc_w  : tc_s;
      a = (s == 0) ? any_w : any_s;
      et = '0;
      for (int i = 0; i < NCH; i++) begin
        et[i] = m_tc[s][i];
        check_val($sformatf("%s_%s_out%0d", phase, (s == 0) ? "wrap" : "sat", i),
                  32'(o[i*W +: W]), 32'(m_cnt[s][i]));
      end
      check_val($sformatf("%s_%s_tc", phase, (s == 0) ? "wrap" : "sat"), 32'(t), 32'(et));
      check_val($sformatf("%s_%s_any", phase, (s == 0) ? "wrap" : "sat"), 32'(a), 32'(|et));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change around the rising edge; the DUT samples on the falling edge.
  task automatic cycle(input string phase);
    @(negedge clk);
    model_step();
    @(posedge clk);
    check_all(phase);
  endtask

  task automatic idle_inputs();
    en = '0; dir = '0; clr = '0; load = '0;
  endtask

  task automatic set_ch(input int i, input logic [W-1:0] lv, input logic [W-1:0] lim);
    load_val[i*W +: W] = lv;
    limit[i*W +: W]    = lim;
  endtask

  task automatic random_cycles(input int n, input string phase);
    for (int k = 0; k < n; k++) begin
      en   = NCH'($urandom);
      dir  = NCH'($urandom);
      clr  = '0;
      load = '0;
      for (int i = 0; i < NCH; i++) begin
        clr[i]  = ($urandom_range(0, 9) == 0);
        load[i] = ($urandom_range(0, 7) == 0);
        load_val[i*W +: W] = W'($urandom_range(0, 15));
        if ($urandom_range(0, 5) == 0) limit[i*W +: W] = W'($urandom_range(0, 12));
      end
      cycle(phase);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    load_val = '0;
    limit    = '0;
    model_reset();

    // Reset held from time zero.
    repeat (2) @(posedge clk);
    check_all("reset");
    rst = 1'b1;

    // First step from all ones wraps to zero with no tc, then counts to limit 3.
    set_ch(0, 8'h00, 8'd3);
    en[0] = 1'b1; dir[0] = 1'b1;
    repeat (5) cycle("first_step");

    // Limit zero counting up: every step is terminal and the count stays 0.
    idle_inputs();
    clr[0] = 1'b1;
    cycle("lim0_clr");
    clr[0] = 1'b0;
    set_ch(0, 8'h00, 8'd0);
    en[0] = 1'b1; dir[0] = 1'b1;
    repeat (2) cycle("lim0_up");

    // Load the limit and keep stepping up: saturate holds, wrap returns to 0.
    idle_inputs();
    set_ch(1, 8'd5, 8'd5);
    load[1] = 1'b1;
    cycle("sat_load");
    load[1] = 1'b0;
    en[1] = 1'b1; dir[1] = 1'b1;
    repeat (2) cycle("sat_up");

    // Down count through zero: wrap reloads the limit, saturate holds 0.
    idle_inputs();
    set_ch(2, 8'd1, 8'd9);
    load[2] = 1'b1;
    cycle("down_load");
    load[2] = 1'b0;
    en[2] = 1'b1; dir[2] = 1'b0;
    repeat (3) cycle("down_step");

    // Priority: clear beats load and enable, then load beats enable.
    idle_inputs();
    set_ch(3, 8'h42, 8'd200);
    clr[3] = 1'b1; load[3] = 1'b1; en[3] = 1'b1; dir[3] = 1'b1;
    cycle("prio_clr");
    clr[3] = 1'b0;
    cycle("prio_load");

    // Mixed traffic on all channels.
    for (int i = 0; i < NCH; i++) limit[i*W +: W] = W'($urandom_range(2, 10));
    random_cycles(24, "rand_a");

    // Reset asserted between edges acts immediately and discards the counts.
    #2 rst = 1'b0;
    #1 model_reset();
    check_all("mid_reset");
    idle_inputs();
    @(posedge clk);
    check_all("reset_hold");
    rst = 1'b1;
    random_cycles(24, "rand_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Time limit so the run always ends with its summary.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, failures=%0d", n_fail);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
